alu_exec: RTL

Execute-stage ALU for the RV32 datapath. It sits directly downstream of the ALU decoder and consumes its 4-bit ALUop together with the two operands selected by the datapath. It produces a registered result behind a valid/ready handshake. Shifts run on an iterative 1-bit-per-cycle shifter to save area, so shift latency depends on the shift amount; all other operations take one cycle.

---
 rtl/alu_exec.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU for the RV32 datapath.
// Registered result behind a valid/ready handshake. Shifts iterate one bit
// per cycle, so shift latency tracks the shift amount; every other op
// completes in a single cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   request can be accepted this cycle (combinational)
//   ALUop      4-bit operation code
//   A          operand A / shift source
//   B          operand B / shift amount in B[$clog2(WIDTH)-1:0]
//   flush      synchronous kill of in-flight and pending work
//   out_valid  result holds a valid value
//   out_ready  consumer accepts result this cycle
//   result     registered result
//   busy       high while the iterative shifter is running
module alu_exec #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUop,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int unsigned SHW = $clog2(WIDTH);

   // ALUop encoding shared with the decoder
   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_AND    = 4'd2;
   localparam logic [3:0] ALU_OR     = 4'd3;
   localparam logic [3:0] ALU_XOR    = 4'd4;
   localparam logic [3:0] ALU_SLT    = 4'd5;
   localparam logic [3:0] ALU_SLTU   = 4'd6;
   localparam logic [3:0] ALU_SLL    = 4'd7;
   localparam logic [3:0] ALU_SRL    = 4'd8;
   localparam logic [3:0] ALU_SRA    = 4'd9;
   localparam logic [3:0] ALU_COPY_B = 4'd10;
   localparam logic [3:0] ALU_XXX    = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Registered state
   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [SHW-1:0]   r_cnt;
   logic             r_left;
   logic             r_arith;
   logic [WIDTH-1:0] r_result;

   // Next-state values
   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_shreg_nxt;
   logic [SHW-1:0]   w_cnt_nxt;
   logic             w_left_nxt;
   logic             w_arith_nxt;
   logic [WIDTH-1:0] w_result_nxt;

   // Datapath helpers
   logic [SHW-1:0]   w_amt;
   logic             w_is_shift;
   logic             w_accept;
   logic [WIDTH-1:0] w_alu_res;
   logic [WIDTH-1:0] w_shift_step;

   assign w_amt      = B[SHW-1:0];
   assign w_is_shift = (ALUop == ALU_SLL) || (ALUop == ALU_SRL) || (ALUop == ALU_SRA);

   assign out_valid  = (r_state == ST_DONE);
   assign busy       = (r_state == ST_SHIFT);
   assign result     = r_result;
   assign in_ready   = (r_state != ST_SHIFT) && (!out_valid || out_ready) && !flush;
   assign w_accept   = in_valid && in_ready;

   // Single-cycle ALU; shift codes return A, which is the k=0 shift result
   always_comb begin
      w_alu_res = '0;
      case (ALUop)
         ALU_ADD:    w_alu_res = A + B;
         ALU_SUB:    w_alu_res = A - B;
         ALU_AND:    w_alu_res = A & B;
         ALU_OR:     w_alu_res = A | B;
         ALU_XOR:    w_alu_res = A ^ B;
         ALU_SLT:    w_alu_res = WIDTH'($signed(A) < $signed(B));
         ALU_SLTU:   w_alu_res = WIDTH'(A < B);
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:    w_alu_res = A;
         ALU_COPY_B: w_alu_res = B;
         ALU_XXX:    w_alu_res = '0;
         default:    w_alu_res = '0;
      endcase
   end

   // One-bit shift of the iterating register; SRA replicates the MSB
   always_comb begin
      w_shift_step = '0;
      if (r_left) begin
         w_shift_step = {r_shreg[WIDTH-2:0], 1'b0};
      end else begin
         w_shift_step = {r_arith & r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
      end
   end

   // Next-state and datapath update
   always_comb begin
      w_state_nxt  = r_state;
      w_shreg_nxt  = r_shreg;
      w_cnt_nxt    = r_cnt;
      w_left_nxt   = r_left;
      w_arith_nxt  = r_arith;
      w_result_nxt = r_result;

      if (flush) begin
         // Kill everything; result register keeps its last value
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
      end else if (w_accept) begin
         // Accept only happens from IDLE or from DONE being drained
         if (w_is_shift && (w_amt != '0)) begin
            w_shreg_nxt = A;
            w_cnt_nxt   = w_amt;
            w_left_nxt  = (ALUop == ALU_SLL);
            w_arith_nxt = (ALUop == ALU_SRA);
            w_state_nxt = ST_SHIFT;
         end else begin
            w_result_nxt = w_alu_res;
            w_state_nxt  = ST_DONE;
         end
      end else begin
         case (r_state)
            ST_SHIFT: begin
               w_shreg_nxt = w_shift_step;
               w_cnt_nxt   = r_cnt - SHW'(1);
               if (r_cnt == SHW'(1)) begin
                  w_result_nxt = w_shift_step;
                  w_state_nxt  = ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_shreg  <= '0;
         r_cnt    <= '0;
         r_left   <= 1'b0;
         r_arith  <= 1'b0;
         r_result <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_shreg  <= w_shreg_nxt;
         r_cnt    <= w_cnt_nxt;
         r_left   <= w_left_nxt;
         r_arith  <= w_arith_nxt;
         r_result <= w_result_nxt;
      end
   end

endmodule
